// File: rtl/machine_timer_pkg.sv
// Shared register map and reset constants for the machine timer, counter and CSR decode.
package machine_timer_pkg;

  localparam logic [4:0] ADDR_TIME_LO = 5'h00;
  localparam logic [4:0] ADDR_TIME_HI = 5'h04;
  localparam logic [4:0] ADDR_CMP_LO  = 5'h08;
  localparam logic [4:0] ADDR_CMP_HI  = 5'h0C;

  localparam logic [63:0] TIME_RESET_DEFAULT = 64'h0;
  localparam logic [63:0] CMP_RESET_DEFAULT  = 64'hFFFF_FFFF_FFFF_FFFF;

  // Register selected by addr[3:2] once the offset is known to be legal.
  typedef enum logic [1:0] {
    RegTimeLo = 2'd0,
    RegTimeHi = 2'd1,
    RegCmpLo  = 2'd2,
    RegCmpHi  = 2'd3
  } reg_sel_e;

  function automatic logic addr_bad(input logic [4:0] addr);
    return (addr[1:0] != 2'b00) || addr[4];
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the core clock down to the mtime tick; clear restarts the count from zero.
module timer_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] count_q, count_d;

  always_comb begin
    tick    = en && !clear && (count_q == LAST);
    count_d = count_q;
    if (clear) begin
      count_d = 16'h0;
    end else if (en) begin
      count_d = tick ? 16'h0 : count_q + 16'h1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_q <= 16'h0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/machine_timer.sv
// RISC-V machine timer: mtime/mtimecmp behind a 32-bit register window, plus mtip.
module machine_timer
  import machine_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 1,
  parameter logic [63:0] TIME_RESET = TIME_RESET_DEFAULT,
  parameter logic [63:0] CMP_RESET  = CMP_RESET_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        time_en_in,
  input  logic        req_in,
  input  logic        we_in,
  input  logic [4:0]  addr_in,
  input  logic [31:0] wdata_in,
  output logic        ack_out,
  output logic        err_out,
  output logic [31:0] rdata_out,
  output logic [63:0] real_time_out,
  output logic        mtip_out
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, err_q, mtip_q;
  logic        bad, wr, rd, time_wr, tick;
  reg_sel_e    sel;

  assign sel     = reg_sel_e'(addr_in[3:2]);
  assign bad     = addr_bad(addr_in);
  assign wr      = req_in && we_in && !bad;
  assign rd      = req_in && !we_in && !bad;
  assign time_wr = wr && ((sel == RegTimeLo) || (sel == RegTimeHi));

  timer_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .en     (time_en_in),
    .clear  (time_wr),
    .tick   (tick)
  );

  always_comb begin
    mtime_d  = mtime_q;
    cmp_d    = cmp_q;
    shadow_d = shadow_q;
    rdata_d  = 32'h0;
    if (tick) begin
      mtime_d = mtime_q + 64'h1;
    end
    // The prescaler suppresses tick on mtime writes, so the write value lands unmodified.
    if (wr) begin
      unique case (sel)
        RegTimeLo: mtime_d = {mtime_q[63:32], wdata_in};
        RegTimeHi: mtime_d = {wdata_in, mtime_q[31:0]};
        RegCmpLo:  cmp_d   = {cmp_q[63:32], wdata_in};
        RegCmpHi:  cmp_d   = {wdata_in, cmp_q[31:0]};
      endcase
    end
    if (rd) begin
      unique case (sel)
        RegTimeLo: begin
          rdata_d  = mtime_q[31:0];
          shadow_d = mtime_q[63:32];
        end
        RegTimeHi: rdata_d = shadow_q;
        RegCmpLo:  rdata_d = cmp_q[31:0];
        RegCmpHi:  rdata_d = cmp_q[63:32];
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mtime_q  <= TIME_RESET;
      cmp_q    <= CMP_RESET;
      shadow_q <= 32'h0;
      rdata_q  <= 32'h0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      mtip_q   <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
      ack_q    <= req_in;
      err_q    <= req_in && bad;
      mtip_q   <= (mtime_q >= cmp_q);
    end
  end

  assign ack_out       = ack_q;
  assign err_out       = err_q;
  assign rdata_out     = rdata_q;
  assign real_time_out = mtime_q;
  assign mtip_out      = mtip_q;

endmodule
